prog_loader: RTL and testbench

Boot-time program loader for the 16-bit multicycle CPU. It receives a framed byte stream from an upstream byte source, such as a serial receiver, and assembles big-endian 16-bit instruction words. Each word is written into the CPU's 256-entry instruction/data memory through that memory's write port. The loader holds the CPU in reset while loading and releases it only after the frame checksum verifies.

---
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 123 ++++++++++++
 tb/tb_prog_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
//   rx_valid/rx_data/rx_ready : upstream byte handshake
//   mem_we/mem_addr/mem_wdata : instruction memory write port
// slave modport is the loader; master modport is the upstream/memory side.
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses HDR, COUNT, ADDR, COUNT big-endian words,
// CHK from a byte stream, writes each word into instruction memory and holds
// the CPU in reset until a frame's checksum verifies.
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : byte handshake in, memory write port out
//   cpu_hold        : 1 holds the CPU in reset (low only after a good frame)
//   done / err      : last frame verified / last frame failed its checksum
module prog_loader #(
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  prog_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_COUNT, S_ADDR, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [BYTE_W-1:0]   sum_add;
  logic                accept;

  // Outputs decoded purely from registered state; no path from rx_* inputs.
  assign bus.rx_ready  = (state_q != S_WRITE);
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = {hi_q, lo_q};
  assign cpu_hold      = (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);

  assign accept  = bus.rx_valid && (state_q != S_WRITE);
  assign sum_add = BYTE_W'(sum_q + bus.rx_data);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sum_q   <= sum_d;
    end
  end

  // Frame parser next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && bus.rx_data == HDR) begin
          state_d = S_COUNT;
          sum_d   = '0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          cnt_d   = bus.rx_data;
          sum_d   = sum_add;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d  = bus.rx_data;
          sum_d   = sum_add;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = bus.rx_data;
          sum_d   = sum_add;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          lo_d    = bus.rx_data;
          sum_d   = sum_add;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // COUNT of 0 wraps through 255..1, giving 256 words
        addr_d  = BYTE_W'(addr_q + 8'd1);
        cnt_d   = BYTE_W'(cnt_q - 8'd1);
        state_d = (cnt_q == 8'd1) ? S_CHK : S_HI;
      end
      S_CHK: begin
        if (accept) begin
          state_d = (sum_add == 8'd0) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frame table, multi-cycle
// corner sequences and randomized frames against a frame-level model.
module tb_prog_loader;

  localparam int unsigned NB = 12;

  logic clk = 1'b0;
  logic rst;
  logic cpu_hold, done, err;

  prog_loader_if ifc();

  prog_loader #(.HDR(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] wq[$];
  int stalls = 0;
  int ready_bad = 0;

  // Capture every memory write as {addr, data}; rx_ready must be the inverse of mem_we
  always @(negedge clk) begin
    if (ifc.mem_we) wq.push_back({ifc.mem_addr, ifc.mem_wdata});
    if (ifc.rx_ready == ifc.mem_we) ready_bad++;
  end

  always @(posedge clk) begin
    if (ifc.rx_valid && !ifc.rx_ready) stalls++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer a byte and hold it until accepted; rx_valid stays high afterwards
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    while (!ifc.rx_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask

  task automatic end_frame();
    ifc.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic send_nominal();
    logic [7:0] fr [8];
    fr = '{8'hA5, 8'h02, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
    foreach (fr[k]) send_byte(fr[k]);
    end_frame();
  endtask

  task automatic chk_write(input string name, input int idx, input logic [23:0] exp);
    logic [23:0] got;
    got = (idx < wq.size()) ? wq[idx] : 24'hxxxxxx;
    chk(name, 32'(got), 32'(exp));
  endtask

  typedef struct {
    logic [0:NB-1][7:0] b;
    int                 n;
    int                 nw;
    logic [23:0]        w0;
    logic [23:0]        w1;
    logic               dn;
    logic               er;
  } vec_t;

  vec_t vecs[5];

  // Random-frame model state
  logic [7:0] r_cnt, r_addr, r_chk, r_nz;
  logic [7:0] r_d [512];
  int         r_words, r_sum, r_noise;
  logic       r_good;

  initial begin
    vecs[0] = '{b: {8'hA5, 8'h02, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30, 32'h0},
                n: 8, nw: 2, w0: 24'h10_1234, w1: 24'h11_ABCD, dn: 1'b1, er: 1'b0};
    vecs[1] = '{b: {8'hA5, 8'h02, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFC, 32'h0},
                n: 8, nw: 2, w0: 24'hFF_0001, w1: 24'h00_0002, dn: 1'b1, er: 1'b0};
    vecs[2] = '{b: {8'hA5, 8'h02, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h31, 32'h0},
                n: 8, nw: 2, w0: 24'h10_1234, w1: 24'h11_ABCD, dn: 1'b0, er: 1'b1};
    vecs[3] = vecs[0];
    // Noise from DONE, then an in-frame HDR as data; 01+20+A5+A5 = 6B, so CHK = 95
    vecs[4] = '{b: {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h20, 8'hA5, 8'hA5, 8'h95, 24'h0},
                n: 9, nw: 1, w0: 24'h20_A5A5, w1: 24'h0, dn: 1'b1, er: 1'b0};

    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rx_ready", 32'(ifc.rx_ready), 1);
    chk("rst_mem_we", 32'(ifc.mem_we), 0);
    chk("rst_mem_addr", 32'(ifc.mem_addr), 0);
    chk("rst_mem_wdata", 32'(ifc.mem_wdata), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Noise in IDLE: discarded, no writes, CPU still held
    wq.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    end_frame();
    chk("noise_writes", 32'(wq.size()), 0);
    chk("noise_hold", 32'(cpu_hold), 1);
    chk("noise_done", 32'(done), 0);
    chk("noise_err", 32'(err), 0);

    // Directed frame table
    for (int i = 0; i < 5; i++) begin
      wq.delete();
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k]);
      end_frame();
      chk($sformatf("v%0d_nwrites", i), 32'(wq.size()), 32'(vecs[i].nw));
      chk_write($sformatf("v%0d_w0", i), 0, vecs[i].w0);
      if (vecs[i].nw > 1) chk_write($sformatf("v%0d_w1", i), 1, vecs[i].w1);
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].er));
      chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(!vecs[i].dn));
    end

    // Backpressure: valid held high throughout, one stall after each write
    wq.delete();
    stalls = 0;
    send_nominal();
    chk("bp_stalls", 32'(stalls), 2);
    chk("bp_nwrites", 32'(wq.size()), 2);
    chk_write("bp_w0", 0, 24'h10_1234);
    chk_write("bp_w1", 1, 24'h11_ABCD);
    chk("bp_done", 32'(done), 1);

    // Reset mid-frame after the first word has been written
    wq.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    ifc.rx_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rx_ready", 32'(ifc.rx_ready), 1);
    chk("mid_mem_we", 32'(ifc.mem_we), 0);
    chk("mid_mem_addr", 32'(ifc.mem_addr), 0);
    chk("mid_mem_wdata", 32'(ifc.mem_wdata), 0);
    chk("mid_cpu_hold", 32'(cpu_hold), 1);
    chk("mid_done", 32'(done), 0);
    chk("mid_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_nwrites", 32'(wq.size()), 1);
    chk_write("mid_w0", 0, 24'h10_1234);
    wq.delete();
    send_nominal();
    chk("mid_reload_nwrites", 32'(wq.size()), 2);
    chk("mid_reload_done", 32'(done), 1);

    // Randomized frames; frame 0 exercises COUNT=0 (256 words)
    for (int f = 0; f < 40; f++) begin
      r_cnt   = (f == 0) ? 8'd0 : 8'($urandom_range(1, 5));
      r_words = (r_cnt == 8'd0) ? 256 : int'(r_cnt);
      r_addr  = 8'($urandom_range(0, 255));
      r_sum   = int'(r_cnt) + int'(r_addr);
      for (int k = 0; k < 2 * r_words; k++) begin
        r_d[k] = 8'($urandom_range(0, 255));
        r_sum += int'(r_d[k]);
      end
      r_good = ($urandom_range(0, 3) != 0);
      r_chk  = 8'(256 - (r_sum % 256));
      if (!r_good) r_chk = 8'(int'(r_chk) + int'($urandom_range(1, 255)));
      r_noise = int'($urandom_range(0, 2));
      wq.delete();
      for (int k = 0; k < r_noise; k++) begin
        r_nz = 8'($urandom_range(0, 255));
        if (r_nz == 8'hA5) r_nz = 8'h3C;
        send_byte(r_nz);
      end
      send_byte(8'hA5);
      send_byte(r_cnt);
      send_byte(r_addr);
      for (int k = 0; k < 2 * r_words; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          ifc.rx_valid = 1'b0;
          @(negedge clk);
        end
        send_byte(r_d[k]);
      end
      send_byte(r_chk);
      end_frame();
      chk($sformatf("r%0d_nwrites", f), 32'(wq.size()), 32'(r_words));
      for (int k = 0; k < r_words; k++)
        chk_write($sformatf("r%0d_w%0d", f, k), k,
                  {8'(int'(r_addr) + k), r_d[2 * k], r_d[2 * k + 1]});
      chk($sformatf("r%0d_done", f), 32'(done), 32'(r_good));
      chk($sformatf("r%0d_err", f), 32'(err), 32'(!r_good));
      chk($sformatf("r%0d_hold", f), 32'(cpu_hold), 32'(!r_good));
    end

    chk("ready_vs_we", 32'(ready_bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
